// File: rtl/vpu_line_compositor_pkg.sv
// Shared types and width helpers for the VPU line compositor and its line buffers.
package vpu_line_compositor_pkg;

   localparam int VPU_LAYERS_MAX = 8;
   localparam int VPU_IDX_W      = 8;
   localparam int VPU_PRIO_W     = 2;

   typedef struct packed {
      logic [VPU_PRIO_W-1:0] prio;
      logic [VPU_IDX_W-1:0]  idx;
   } lb_entry_t;

   localparam int VPU_ENTRY_W = $bits(lb_entry_t);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } lc_state_e;

   // Width of an index into n items, never less than one bit.
   function automatic int clog2w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vpu_line_compositor_linebuf.sv
// One layer's double-buffered line store: port A writes, port B reads and clears behind itself.
module vpu_linebuf
   import vpu_line_compositor_pkg::*;
#(
   parameter int LINE_W = 320,
   parameter int DW     = VPU_ENTRY_W
) (
   input  logic                       clk_i,
   input  logic                       wr_en_i,
   input  logic                       wr_bank_i,
   input  logic [clog2w(LINE_W)-1:0]  wr_x_i,
   input  logic [DW-1:0]              wr_data_i,
   input  logic                       rd_en_i,
   input  logic                       rd_bank_i,
   input  logic [clog2w(LINE_W)-1:0]  rd_x_i,
   output logic [DW-1:0]              rd_data_o
);

   localparam int AW = clog2w(2 * LINE_W);

   logic [DW-1:0] mem [2*LINE_W];
   logic [DW-1:0] rd_data_q;
   logic [AW-1:0] wa;
   logic [AW-1:0] ra;

   assign wa = wr_bank_i ? AW'(LINE_W) + AW'(wr_x_i) : AW'(wr_x_i);
   assign ra = rd_bank_i ? AW'(LINE_W) + AW'(rd_x_i) : AW'(rd_x_i);

   // Banks always differ between ports, so the write and the clear never collide.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem[wa] <= wr_data_i;
      if (rd_en_i) begin
         rd_data_q <= mem[ra];
         mem[ra]   <= '0;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vpu_line_compositor.sv
// Multi-layer line compositor: per-layer line buffers, priority select, palette lookup.
//  state    | meaning
//  ST_IDLE  | waiting for line_start; writes still accepted
//  ST_SCAN  | issuing read-with-clear of x = 0..LINE_W-1, one per pix_en beat
//  ST_DRAIN | two pix_en beats flushing select and palette stages
module vpu_line_compositor
   import vpu_line_compositor_pkg::*;
#(
   parameter int LAYERS  = 4,
   parameter int LINE_W  = 320,
   parameter int IDX_W   = VPU_IDX_W,
   parameter int PRIO_W  = VPU_PRIO_W,
   parameter int COLOR_W = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              line_start,
   input  logic                              pix_en,
   input  logic                              wr_en,
   input  logic [clog2w(LAYERS)-1:0]         wr_layer,
   input  logic [clog2w(LINE_W)-1:0]         wr_x,
   input  logic [IDX_W-1:0]                  wr_idx,
   input  logic [PRIO_W-1:0]                 wr_prio,
   input  logic [COLOR_W-1:0]                backdrop,
   output logic                              pal_en,
   output logic [clog2w(LAYERS)+IDX_W-1:0]   pal_addr,
   input  logic [COLOR_W-1:0]                pal_dout,
   output logic                              out_valid,
   output logic [clog2w(LINE_W)-1:0]         out_x,
   output logic [COLOR_W-1:0]                out_color,
   output logic                              bank,
   output logic                              busy,
   output logic                              overrun,
   input  logic                              overrun_clr
);

   localparam int NL = (LAYERS < VPU_LAYERS_MAX) ? LAYERS : VPU_LAYERS_MAX;
   localparam int LW = clog2w(LAYERS);
   localparam int XW = clog2w(LINE_W);
   localparam int EW = PRIO_W + IDX_W;

   lc_state_e     state_q, state_d;
   logic          bank_q, bank_d;
   logic [XW-1:0] x_q, x_d;
   logic          drn_q, drn_d;
   logic          ovr_q, ovr_d;
   logic          issue;
   logic          x_ok;

   logic [EW-1:0] rd_data [NL];

   logic          s1_vld_q, s2_vld_q, s2_bd_q;
   logic [XW-1:0] s1_x_q, s2_x_q;
   logic          out_valid_q;
   logic [XW-1:0] out_x_q;
   logic [COLOR_W-1:0] out_color_q;

   logic              hit;
   logic [LW-1:0]     win_layer;
   logic [IDX_W-1:0]  win_idx;
   logic [PRIO_W-1:0] win_prio;

   assign x_ok = (wr_x < XW'(LINE_W));

   for (genvar l = 0; l < NL; l++) begin : g_layer
      vpu_linebuf #(.LINE_W(LINE_W), .DW(EW)) u_lb (
         .clk_i     (clk),
         .wr_en_i   (wr_en && x_ok && (wr_layer == LW'(l))),
         .wr_bank_i (bank_q),
         .wr_x_i    (wr_x),
         .wr_data_i ({wr_prio, wr_idx}),
         .rd_en_i   (issue),
         .rd_bank_i (~bank_q),
         .rd_x_i    (x_q),
         .rd_data_o (rd_data[l])
      );
   end

   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      x_d     = x_q;
      drn_d   = drn_q;
      issue   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (line_start) begin
               bank_d  = ~bank_q;
               x_d     = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (pix_en) begin
               issue = 1'b1;
               if (x_q == XW'(LINE_W - 1)) begin
                  state_d = ST_DRAIN;
                  drn_d   = 1'b0;
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (pix_en) begin
               if (drn_q) state_d = ST_IDLE;
               else       drn_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A set in the same cycle as a clear must win.
      ovr_d = (ovr_q & ~overrun_clr) | (line_start & (state_q != ST_IDLE));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bank_q  <= 1'b0;
         x_q     <= '0;
         drn_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         x_q     <= x_d;
         drn_q   <= drn_d;
         ovr_q   <= ovr_d;
      end
   end

   // Ascending scan with strict '>' leaves ties with the lowest layer.
   always_comb begin
      hit       = 1'b0;
      win_layer = '0;
      win_idx   = '0;
      win_prio  = '0;
      for (int l = 0; l < NL; l++) begin
         if ((rd_data[l][IDX_W-1:0] != '0) &&
             (!hit || (rd_data[l][EW-1:IDX_W] > win_prio))) begin
            hit       = 1'b1;
            win_layer = LW'(l);
            win_prio  = rd_data[l][EW-1:IDX_W];
            win_idx   = rd_data[l][IDX_W-1:0];
         end
      end
   end

   assign pal_en   = pix_en & s1_vld_q & hit;
   assign pal_addr = {win_layer, win_idx};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         s2_bd_q     <= 1'b0;
         s1_x_q      <= '0;
         s2_x_q      <= '0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_color_q <= '0;
      end else begin
         out_valid_q <= 1'b0;
         if (pix_en) begin
            s1_vld_q <= issue;
            s1_x_q   <= x_q;
            s2_vld_q <= s1_vld_q;
            s2_x_q   <= s1_x_q;
            s2_bd_q  <= ~hit;
            if (s2_vld_q) begin
               out_valid_q <= 1'b1;
               out_x_q     <= s2_x_q;
               out_color_q <= s2_bd_q ? backdrop : pal_dout;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_color = out_color_q;
   assign bank      = bank_q;
   assign busy      = (state_q != ST_IDLE);
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_vpu_line_compositor.sv
// Randomized bench for vpu_line_compositor against a per-line reference model.
module tb_vpu_line_compositor;

   localparam int LAYERS  = 4;
   localparam int LINE_W  = 320;
   localparam int IDX_W   = 8;
   localparam int PRIO_W  = 2;
   localparam int COLOR_W = 32;
   localparam int LIMIT   = 4000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        line_start = 1'b0;
   logic        pix_en = 1'b1;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_layer = '0;
   logic [8:0]  wr_x = '0;
   logic [7:0]  wr_idx = '0;
   logic [1:0]  wr_prio = '0;
   logic [31:0] backdrop = '0;
   logic        pal_en;
   logic [9:0]  pal_addr;
   logic [31:0] pal_dout = '0;
   logic        out_valid;
   logic [8:0]  out_x;
   logic [31:0] out_color;
   logic        bank;
   logic        busy;
   logic        overrun;
   logic        overrun_clr = 1'b0;

   always #5 clk = ~clk;

   vpu_line_compositor #(
      .LAYERS(LAYERS), .LINE_W(LINE_W), .IDX_W(IDX_W), .PRIO_W(PRIO_W), .COLOR_W(COLOR_W)
   ) dut (
      .clk(clk), .rst(rst), .line_start(line_start), .pix_en(pix_en),
      .wr_en(wr_en), .wr_layer(wr_layer), .wr_x(wr_x), .wr_idx(wr_idx), .wr_prio(wr_prio),
      .backdrop(backdrop), .pal_en(pal_en), .pal_addr(pal_addr), .pal_dout(pal_dout),
      .out_valid(out_valid), .out_x(out_x), .out_color(out_color),
      .bank(bank), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pal_f(input logic [9:0] a);
      if (a == 10'd5) return 32'hAABBCCDD;
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Registered palette RAM.
   always @(posedge clk) if (pal_en) pal_dout <= pal_f(pal_addr);

   typedef struct {
      int          x;
      logic [31:0] c;
   } pix_t;

   logic [9:0] mbuf [2][LAYERS][LINE_W];
   int         m_bank = 0;
   pix_t       eq[$];
   logic [9:0] aq[$];
   bit         chk_on = 1'b0;
   int         pe_mode = 0;
   pix_t       mon_p;
   logic [9:0] mon_a;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (pe_mode)
            0: pix_en = 1'b1;
            1: pix_en = ~pix_en;
            default: pix_en = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         if (out_valid) begin
            if (eq.size() == 0) chk("spurious_out_valid", 1, 0);
            else begin
               mon_p = eq.pop_front();
               chk("out_x", 64'(out_x), 64'(mon_p.x));
               chk("out_color", 64'(out_color), 64'(mon_p.c));
            end
         end
         if (pal_en) begin
            if (aq.size() == 0) chk("spurious_pal_en", 1, 0);
            else begin
               mon_a = aq.pop_front();
               chk("pal_addr", 64'(pal_addr), 64'(mon_a));
            end
         end
      end
   end

   task automatic do_wr(input int l, input int x, input int idx, input int p);
      wr_en = 1'b1; wr_layer = 2'(l); wr_x = 9'(x); wr_idx = 8'(idx); wr_prio = 2'(p);
      if (x < LINE_W) mbuf[m_bank][l][x] = {2'(p), 8'(idx)};
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic rand_wr();
      int x;
      x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(LINE_W, 511)) :
          ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, LINE_W - 1));
      do_wr($urandom_range(0, LAYERS - 1), x,
            ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255)), $urandom_range(0, 3));
   endtask

   // Winner: highest priority level that has any opaque pixel, first layer at that level.
   task automatic model_line(input int rb);
      for (int x = 0; x < LINE_W; x++) begin
         bit         found = 1'b0;
         logic [9:0] a = '0;
         pix_t       p;
         for (int pr = 3; pr >= 0 && !found; pr--)
            for (int l = 0; l < LAYERS && !found; l++)
               if (mbuf[rb][l][x][7:0] != 8'd0 && int'(mbuf[rb][l][x][9:8]) == pr) begin
                  found = 1'b1;
                  a = {2'(l), mbuf[rb][l][x][7:0]};
               end
         p.x = x;
         p.c = found ? pal_f(a) : backdrop;
         eq.push_back(p);
         if (found) aq.push_back(a);
         for (int l = 0; l < LAYERS; l++) mbuf[rb][l][x] = '0;
      end
   endtask

   // wr_mode: 0 none, 1 random writes, 2 zero-fill of the new write bank.
   task automatic run_line(input int wr_mode, input int ovr_at, input bit lat_chk);
      int n;
      backdrop = $urandom;
      model_line(m_bank);
      m_bank ^= 1;
      chk_on = 1'b1;
      @(posedge clk); #1 line_start = 1'b1;
      @(posedge clk); #1 line_start = 1'b0;
      chk("bank_swap", 64'(bank), 64'(m_bank));
      chk("busy_start", 64'(busy), 1);
      if (lat_chk) begin
         n = 0;
         while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
         chk("first_pixel_latency", 64'(n), 3);
      end
      if (ovr_at > 0) begin
         repeat (ovr_at) @(posedge clk);
         #1 line_start = 1'b1;
         @(posedge clk); #1 line_start = 1'b0;
         chk("overrun_set", 64'(overrun), 1);
         chk("overrun_bank_hold", 64'(bank), 64'(m_bank));
         overrun_clr = 1'b1; line_start = 1'b1;
         @(posedge clk); #1 overrun_clr = 1'b0; line_start = 1'b0;
         chk("overrun_set_wins", 64'(overrun), 1);
      end
      if (wr_mode == 1) repeat (150) rand_wr();
      if (wr_mode == 2)
         for (int l = 0; l < LAYERS; l++)
            for (int x = 0; x < LINE_W; x++) do_wr(l, x, 0, 0);
      n = 0;
      while ((eq.size() != 0 || aq.size() != 0) && n < LIMIT) begin @(posedge clk); n++; end
      chk("pixels_left", 64'(eq.size()), 0);
      chk("pal_reads_left", 64'(aq.size()), 0);
      repeat (3) @(posedge clk);
      #1 chk("busy_end", 64'(busy), 0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_bank"}, 64'(bank), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_overrun"}, 64'(overrun), 0);
      chk({tag, "_out_valid"}, 64'(out_valid), 0);
      chk({tag, "_out_x"}, 64'(out_x), 0);
      chk({tag, "_out_color"}, 64'(out_color), 0);
      chk({tag, "_pal_en"}, 64'(pal_en), 0);
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int l = 0; l < LAYERS; l++)
            for (int x = 0; x < LINE_W; x++) mbuf[b][l][x] = '0;
      repeat (3) @(posedge clk);
      #1 check_reset("reset");
      rst = 1'b0;

      // Both banks get known-empty contents before clear-on-read is relied on.
      for (int l = 0; l < LAYERS; l++)
         for (int x = 0; x < LINE_W; x++) do_wr(l, x, 0, 0);
      run_line(2, 0, 1'b1);

      do_wr(0, 10, 5, 0);
      run_line(0, 0, 1'b1);

      do_wr(1, 20, 7, 3); do_wr(0, 20, 9, 1);
      do_wr(0, 30, 9, 2); do_wr(2, 30, 4, 2);
      do_wr(3, 40, 8, 1); do_wr(3, 40, 6, 2);
      do_wr(0, 320, 7, 3); do_wr(1, 400, 7, 3);
      run_line(1, 0, 1'b1);

      pe_mode = 2;
      run_line(1, 0, 1'b0);
      run_line(0, 0, 1'b0);
      pe_mode = 0;
      run_line(0, 0, 1'b1);

      repeat (100) rand_wr();
      run_line(1, 100, 1'b1);
      @(posedge clk); #1 overrun_clr = 1'b1;
      @(posedge clk); #1 overrun_clr = 1'b0;
      chk("overrun_clr", 64'(overrun), 0);

      pe_mode = 1;
      run_line(0, 0, 1'b0);
      pe_mode = 0;

      chk_on = 1'b0;
      do_wr(2, 320, 9, 1);
      @(posedge clk); #1 line_start = 1'b1;
      @(posedge clk); #1 line_start = 1'b0;
      repeat (50) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 check_reset("midscan_reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("idle_after_reset", 64'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
